// File: rtl/datapath_run_ctrl_if.sv
// Run-control bus between a datapath harness and datapath_run_ctrl.
// The master drives the run commands and trace read index; the slave returns status and trace data.
interface datapath_run_ctrl_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 16
);
  localparam int AW = $clog2(DEPTH);

  logic            start;
  logic            stop;
  logic [XLEN-1:0] pc_in;
  logic [31:0]     instr_in;
  logic [AW-1:0]   rd_addr;
  logic            core_reset;
  logic            running;
  logic            halted;
  logic [1:0]      halt_cause;
  logic [XLEN-1:0] cycle_count;
  logic [AW:0]     trace_count;
  logic [XLEN-1:0] rd_data;

  modport master (
    output start, stop, pc_in, instr_in, rd_addr,
    input  core_reset, running, halted, halt_cause, cycle_count, trace_count, rd_data
  );

  modport slave (
    input  start, stop, pc_in, instr_in, rd_addr,
    output core_reset, running, halted, halt_cause, cycle_count, trace_count, rd_data
  );
endinterface

// File: rtl/datapath_run_ctrl.sv
// Run controller for a datapath: holds it in reset, lets it run, and halts on ebreak/ecall/stop/limit.
// A circular buffer records every PC executed during the run for later read-back.
module datapath_run_ctrl #(
  parameter int XLEN       = 32,
  parameter int DEPTH      = 16,
  parameter int RST_HOLD   = 3,
  parameter int MAX_CYCLES = 1024
) (
  input logic                clock,
  input logic                reset,
  datapath_run_ctrl_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int HW = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

  localparam logic [31:0]     EBREAK    = 32'h0010_0073;
  localparam logic [31:0]     ECALL     = 32'h0000_0073;
  localparam logic [XLEN-1:0] MAX_C     = XLEN'(MAX_CYCLES);
  localparam logic [XLEN-1:0] CYC_ONE   = XLEN'(1);
  localparam logic [AW:0]     FULL      = (AW+1)'(DEPTH);
  localparam logic [AW:0]     TC_ONE    = (AW+1)'(1);
  localparam logic [AW-1:0]   WP_ONE    = AW'(1);
  localparam logic [HW-1:0]   HOLD_INIT = HW'(RST_HOLD - 1);
  localparam logic [HW-1:0]   HOLD_ONE  = HW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    RUN  = 2'd2,
    HALT = 2'd3
  } state_t;

  state_t          state_r;
  logic [HW-1:0]   hold_cnt_r;
  logic [AW-1:0]   wptr_r;
  logic [AW:0]     trace_count_r;
  logic [XLEN-1:0] cycle_count_r;
  logic [1:0]      halt_cause_r;
  logic            core_reset_r;
  logic            running_r;
  logic            halted_r;
  logic [XLEN-1:0] trace_mem_r [DEPTH];

  logic [XLEN-1:0] cycle_next_s;
  logic            halt_s;
  logic [1:0]      cause_s;
  logic [AW-1:0]   oldest_s;
  logic [AW-1:0]   rd_idx_s;

  assign cycle_next_s = cycle_count_r + CYC_ONE;

  // Halt decision for the current RUN cycle, ebreak first, then ecall, then stop/limit
  always_comb begin
    halt_s  = 1'b0;
    cause_s = 2'b00;
    if (bus.instr_in == EBREAK) begin
      halt_s  = 1'b1;
      cause_s = 2'b01;
    end else if (bus.instr_in == ECALL) begin
      halt_s  = 1'b1;
      cause_s = 2'b10;
    end else if (bus.stop || (cycle_next_s == MAX_C)) begin
      halt_s  = 1'b1;
      cause_s = 2'b11;
    end else begin
      halt_s  = 1'b0;
      cause_s = 2'b00;
    end
  end

  // Run-control state machine with registered status outputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r       <= IDLE;
      hold_cnt_r    <= '0;
      wptr_r        <= '0;
      trace_count_r <= '0;
      cycle_count_r <= '0;
      halt_cause_r  <= 2'b00;
      core_reset_r  <= 1'b1;
      running_r     <= 1'b0;
      halted_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE, HALT: begin
          if (bus.start) begin
            state_r       <= HOLD;
            hold_cnt_r    <= HOLD_INIT;
            wptr_r        <= '0;
            trace_count_r <= '0;
            cycle_count_r <= '0;
            halt_cause_r  <= 2'b00;
            core_reset_r  <= 1'b1;
            running_r     <= 1'b0;
            halted_r      <= 1'b0;
          end
        end
        HOLD: begin
          if (hold_cnt_r == '0) begin
            state_r      <= RUN;
            core_reset_r <= 1'b0;
            running_r    <= 1'b1;
          end else begin
            hold_cnt_r <= hold_cnt_r - HOLD_ONE;
          end
        end
        RUN: begin
          wptr_r        <= wptr_r + WP_ONE;
          cycle_count_r <= cycle_next_s;
          if (trace_count_r != FULL) begin
            trace_count_r <= trace_count_r + TC_ONE;
          end
          if (halt_s) begin
            state_r      <= HALT;
            halt_cause_r <= cause_s;
            running_r    <= 1'b0;
            halted_r     <= 1'b1;
          end
        end
        default: begin
          state_r      <= IDLE;
          core_reset_r <= 1'b1;
          running_r    <= 1'b0;
          halted_r     <= 1'b0;
        end
      endcase
    end
  end

  // Trace buffer write; contents are never reset, only valid entries are read back
  always_ff @(posedge clock) begin
    if (state_r == RUN) begin
      trace_mem_r[wptr_r] <= bus.pc_in;
    end
  end

  assign oldest_s = (trace_count_r == FULL) ? wptr_r : '0;
  assign rd_idx_s = oldest_s + bus.rd_addr;

  assign bus.rd_data     = trace_mem_r[rd_idx_s];
  assign bus.core_reset  = core_reset_r;
  assign bus.running     = running_r;
  assign bus.halted      = halted_r;
  assign bus.halt_cause  = halt_cause_r;
  assign bus.cycle_count = cycle_count_r;
  assign bus.trace_count = trace_count_r;
endmodule

// File: tb/tb_datapath_run_ctrl.sv
// Self-checking bench for datapath_run_ctrl: directed runs plus randomized runs
// compared against a queue-based model of the run/trace rules.
module tb_datapath_run_ctrl;
  localparam int XLEN       = 32;
  localparam int DEPTH      = 16;
  localparam int AW         = 4;
  localparam int RST_HOLD   = 3;
  localparam int MAX_CYCLES = 24;

  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [31:0] ECALL  = 32'h0000_0073;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  datapath_run_ctrl_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus ();

  datapath_run_ctrl #(
    .XLEN(XLEN), .DEPTH(DEPTH), .RST_HOLD(RST_HOLD), .MAX_CYCLES(MAX_CYCLES)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  logic [XLEN-1:0] trace_q [$];
  int              m_cycles;
  logic [1:0]      m_cause;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_core_reset"}, 64'(bus.core_reset), 64'd1);
    check({tag, "_running"}, 64'(bus.running), 64'd0);
    check({tag, "_halted"}, 64'(bus.halted), 64'd0);
    check({tag, "_cause"}, 64'(bus.halt_cause), 64'd0);
    check({tag, "_cycles"}, 64'(bus.cycle_count), 64'd0);
    check({tag, "_tcount"}, 64'(bus.trace_count), 64'd0);
  endtask

  task automatic read_back(input string tag);
    for (int i = 0; i < trace_q.size(); i++) begin
      bus.rd_addr = AW'(i);
      #1;
      check(tag, 64'(bus.rd_data), 64'(trace_q[i]));
    end
  endtask

  // mode: 0 random, 1 ebreak on 5th cycle, 2 stop on 20th, 3 run to limit, 4 ebreak+stop together
  task automatic run_one(input int mode, input int start_at);
    logic [XLEN-1:0] pc;
    logic [31:0]     ins;
    logic            stp;
    bit              done;
    int              n;
    @(negedge clock);
    bus.stop  = 1'b0;
    bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    check("hold_cycles_clr", 64'(bus.cycle_count), 64'd0);
    check("hold_tcount_clr", 64'(bus.trace_count), 64'd0);
    check("hold_cause_clr", 64'(bus.halt_cause), 64'd0);
    check("hold_halted", 64'(bus.halted), 64'd0);
    for (int i = 0; i < RST_HOLD; i++) begin
      check("hold_core_reset", 64'(bus.core_reset), 64'd1);
      check("hold_running", 64'(bus.running), 64'd0);
      @(negedge clock);
    end
    check("run_entry_running", 64'(bus.running), 64'd1);
    check("run_entry_core_reset", 64'(bus.core_reset), 64'd0);
    trace_q.delete();
    m_cycles = 0;
    m_cause  = 2'b00;
    done     = 1'b0;
    n        = 0;
    while (!done) begin
      case (mode)
        0: begin
          pc  = $urandom;
          ins = ($urandom_range(0, 15) == 0) ? EBREAK :
                ($urandom_range(0, 15) == 0) ? ECALL  : $urandom;
          stp = ($urandom_range(0, 19) == 0);
        end
        1: begin pc = XLEN'(4 * n); ins = (n == 4) ? EBREAK : NOP; stp = 1'b0; end
        2: begin pc = XLEN'(4 * n); ins = NOP; stp = (n == 19); end
        3: begin pc = XLEN'(4 * n); ins = NOP; stp = 1'b0; end
        4: begin pc = XLEN'(4 * n); ins = (n == 2) ? EBREAK : NOP; stp = (n == 2); end
        default: begin pc = '0; ins = NOP; stp = 1'b1; end
      endcase
      bus.pc_in    = pc;
      bus.instr_in = ins;
      bus.stop     = stp;
      bus.start    = (n == start_at);
      trace_q.push_back(pc);
      if (trace_q.size() > DEPTH) void'(trace_q.pop_front());
      m_cycles++;
      if (ins == EBREAK) begin
        m_cause = 2'b01; done = 1'b1;
      end else if (ins == ECALL) begin
        m_cause = 2'b10; done = 1'b1;
      end else if (stp || (m_cycles == MAX_CYCLES)) begin
        m_cause = 2'b11; done = 1'b1;
      end
      n++;
      @(negedge clock);
      bus.start = 1'b0;
      bus.stop  = 1'b0;
      if (!done) check("run_running", 64'(bus.running), 64'd1);
    end
    check("halt_halted", 64'(bus.halted), 64'd1);
    check("halt_running", 64'(bus.running), 64'd0);
    check("halt_core_reset", 64'(bus.core_reset), 64'd0);
    check("halt_cause", 64'(bus.halt_cause), 64'(m_cause));
    check("halt_cycles", 64'(bus.cycle_count), 64'(m_cycles));
    check("halt_tcount", 64'(bus.trace_count), 64'(trace_q.size()));
    read_back("trace_rd");
    for (int k = 0; k < 3; k++) begin
      bus.pc_in    = $urandom;
      bus.instr_in = NOP;
      bus.stop     = 1'b1;
      @(negedge clock);
    end
    bus.stop    = 1'b0;
    bus.rd_addr = '0;
    #1;
    check("freeze_cycles", 64'(bus.cycle_count), 64'(m_cycles));
    check("freeze_cause", 64'(bus.halt_cause), 64'(m_cause));
    check("freeze_tcount", 64'(bus.trace_count), 64'(trace_q.size()));
    check("freeze_halted", 64'(bus.halted), 64'd1);
    check("freeze_rd0", 64'(bus.rd_data), 64'(trace_q[0]));
  endtask

  initial begin
    #300000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    bus.start    = 1'b0;
    bus.stop     = 1'b0;
    bus.pc_in    = '0;
    bus.instr_in = NOP;
    bus.rd_addr  = '0;
    reset        = 1'b0;
    repeat (2) @(negedge clock);
    check_idle("reset");
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check_idle("idle_wait");
    end

    run_one(1, -1);
    run_one(2, 3);
    run_one(3, -1);
    run_one(4, -1);

    // Asynchronous reset while running
    @(negedge clock);
    bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    repeat (RST_HOLD + 5) @(negedge clock);
    check("pre_reset_running", 64'(bus.running), 64'd1);
    #2 reset = 1'b0;
    #1;
    check("async_core_reset", 64'(bus.core_reset), 64'd1);
    check("async_running", 64'(bus.running), 64'd0);
    check("async_tcount", 64'(bus.trace_count), 64'd0);
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check_idle("post_reset");
    end

    for (int r = 0; r < 8; r++) begin
      run_one(0, (r == 2) ? 1 : -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/datapath_run_ctrl.md
DATAPATH_RUN_CTRL -- requirements
Module: datapath_run_ctrl

Interface
REQ-001 Parameter XLEN, default 32, width of PC samples and cycle counter.
REQ-002 Parameter DEPTH, default 16 (power of two, >=2), number of entries in the PC trace buffer.
REQ-003 Parameter RST_HOLD, default 3 (>=1), number of clock cycles core_reset is held high after start.
REQ-004 Parameter MAX_CYCLES, default 1024 (>=1), RUN-cycle limit before forced halt.
REQ-005 clock  input  1  single clock; all state updates on its rising edge.
REQ-006 reset  input  1  asynchronous, active-low block reset.
REQ-007 start  input  1  one-cycle pulse requesting a new run; honoured only in IDLE or HALT.
REQ-008 stop  input  1  level; forces halt while in RUN.
REQ-009 pc_in  input  XLEN  datapath PC, sampled every RUN cycle.
REQ-010 instr_in  input  32  instruction at pc_in.
REQ-011 rd_addr  input  log2(DEPTH)  trace read index; 0 = oldest valid entry.
REQ-012 core_reset  output  1  active-high reset driven to the datapath.
REQ-013 running  output  1  high in RUN.
REQ-014 halted  output  1  high in HALT.
REQ-015 halt_cause  output  2  00 none, 01 ebreak, 10 ecall, 11 limit/stop.
REQ-016 cycle_count  output  XLEN  number of RUN cycles in the current or last run.
REQ-017 trace_count  output  log2(DEPTH)+1  valid trace entries, saturating at DEPTH.
REQ-018 rd_data  output  XLEN  combinational trace entry at rd_addr.

Function
REQ-019 FSM states SHALL be IDLE, HOLD, RUN and HALT, registered and binary encoded.
REQ-020 On start in IDLE or HALT, the block SHALL enter HOLD, clear cycle_count, trace_count, write pointer and halt_cause, and load the hold counter with RST_HOLD-1.
REQ-021 core_reset SHALL be high in IDLE and HOLD and low in RUN and HALT.
REQ-022 HOLD SHALL last exactly RST_HOLD cycles, then transition to RUN.
REQ-023 Each RUN cycle, the block SHALL write pc_in to trace[wptr], increment wptr modulo DEPTH, increment trace_count saturating at DEPTH, and increment cycle_count.
REQ-024 Once trace_count reaches DEPTH, new writes SHALL overwrite the oldest entry (circular); the oldest index is wptr when full and 0 otherwise.
REQ-025 rd_data SHALL equal trace[(oldest + rd_addr) mod DEPTH]; for rd_addr >= trace_count, rd_data is don't-care.
REQ-026 In RUN, instr_in == 32'h00100073 SHALL cause a transition to HALT with cause 01; instr_in == 32'h00000073 SHALL cause a transition to HALT with cause 10. The halting cycle's PC is traced and counted.
REQ-027 In RUN, stop high, or cycle_count reaching MAX_CYCLES after the current increment, SHALL cause a transition to HALT with cause 11.
REQ-028 Priority among simultaneous halt events SHALL be ebreak > ecall > stop/limit.
REQ-029 In HALT, the trace buffer, cycle_count and halt_cause SHALL be frozen until the next start.
REQ-030 start SHALL be ignored in HOLD and RUN.
REQ-031 cycle_count SHALL never wrap; MAX_CYCLES < 2^XLEN.

Reset
REQ-032 Asserting reset low SHALL immediately force IDLE, core_reset=1, running=0, halted=0, halt_cause=00, cycle_count=0, trace_count=0 and wptr=0, asynchronously and in any state.
REQ-033 Trace memory contents SHALL NOT require reset.
REQ-034 After reset deasserts, the block SHALL remain in IDLE until start.

Verification
REQ-035 Reset low mid-RUN -> same cycle: core_reset=1, running=0, trace_count=0; after release, IDLE with all outputs at their reset values.
REQ-036 RST_HOLD=3, start pulse -> core_reset high for exactly 3 cycles after start, then running=1.
REQ-037 PCs 0,4,8,... fed, instr_in=00100073 on the 5th RUN cycle -> halted=1, halt_cause=01, cycle_count=5, trace_count=5, rd_data(0..4)=0,4,8,12,16.
REQ-038 DEPTH=16, 20 RUN cycles with PC=4*n, then stop -> trace_count=16, rd_data(0)=16, rd_data(15)=76.
REQ-039 MAX_CYCLES=8, no halt instruction -> HALT after 8 RUN cycles, cause 11, cycle_count=8.
REQ-040 ebreak and stop in the same cycle -> halt_cause=01; start in HALT -> HOLD with counters cleared.
